// File: rtl/andor_pkg.sv
// Shared types and golden functions for the AND-OR gate checker.
// Holds the FSM state enum, the vector count and expected-value helpers.
package andor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 8;

  function automatic logic exp_x(input logic a, input logic b);
    return a & b;
  endfunction

  function automatic logic exp_y(input logic b, input logic c);
    return b | c;
  endfunction

endpackage

// File: rtl/andor_settle_timer.sv
// Loadable down-counter that holds at zero and flags it.
// Ports: clk, rst_n (sync, active-low), load/value, en (decrement), zero.
module andor_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/andor_stim_checker.sv
// Sweeps all 8 A/B/C vectors into an AND-OR gate and checks X/Y.
// Ports: clk, rst_n, start, x_i, y_i in; a_o/b_o/c_o, busy, done,
// pass, err_cnt, fail_vec, first_fail_idx, first_fail_valid out.
module andor_stim_checker
  import andor_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             x_i,
  input  logic             y_i,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       fail_vec,
  output logic [2:0]       first_fail_idx,
  output logic             first_fail_valid
);

  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST = 3'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t state;
  state_t state_nx;

  logic [2:0]       idx;
  logic             zero;
  logic             mism;
  logic [ERR_W-1:0] err_sat;

  andor_settle_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == DRIVE),
    .en   (state == SETTLE),
    .value(LOAD_VAL),
    .zero (zero)
  );

  // Four-state compare: an X/Z from the gate is a mismatch.
  always_comb begin
    mism = (x_i !== exp_x(a_o, b_o))
        || (y_i !== exp_y(b_o, c_o));
    err_sat = (err_cnt == ERR_MAX)
            ? err_cnt : err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = DRIVE;
      DRIVE:   state_nx = SETTLE;
      SETTLE:  if (zero) state_nx = SAMPLE;
      SAMPLE:  state_nx = (idx == LAST) ? DONE : DRIVE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx              <= '0;
      a_o              <= 1'b0;
      b_o              <= 1'b0;
      c_o              <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      fail_vec         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx              <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_cnt          <= '0;
            fail_vec         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        DRIVE: {a_o, b_o, c_o} <= idx;
        SAMPLE: begin
          if (mism) begin
            err_cnt       <= err_sat;
            fail_vec[idx] <= 1'b1;
            if (!first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          // Last vector: result becomes visible in the DONE cycle.
          if (idx == LAST) begin
            done            <= 1'b1;
            busy            <= 1'b0;
            pass            <= !mism && (err_cnt == '0);
            {a_o, b_o, c_o} <= 3'b000;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_andor_stim_checker.sv
// Self-checking bench: three checkers on gate models with injected faults.
// Expected sweep results are queued at start and popped at done.
module tb_andor_stim_checker;

  typedef struct packed {
    logic [7:0] fv;
    logic [3:0] ec;
    logic [2:0] fi;
    logic       fvld;
    logic       ps;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  int   mode;
  int   checks = 0;
  int   errors = 0;

  logic       x, y, a, b, c, busy, done, pass, fvld;
  logic [3:0] ec;
  logic [7:0] fv;
  logic [2:0] fi;

  logic       xw, yw, aw, bw, cw, busyw, donew, passw, fvldw;
  logic [1:0] ecw;
  logic [7:0] fvw;
  logic [2:0] fiw;

  logic       xs, ys, as_, bs, cs, busys, dones, passs, fvlds;
  logic [3:0] ecs;
  logic [7:0] fvs;
  logic [2:0] fis;

  res_t q_main[$];
  res_t q_w2[$];
  res_t q_s4[$];

  andor_stim_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_i(x), .y_i(y),
    .a_o(a), .b_o(b), .c_o(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(ec), .fail_vec(fv), .first_fail_idx(fi),
    .first_fail_valid(fvld));

  andor_stim_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_i(xw), .y_i(yw),
    .a_o(aw), .b_o(bw), .c_o(cw), .busy(busyw), .done(donew),
    .pass(passw), .err_cnt(ecw), .fail_vec(fvw), .first_fail_idx(fiw),
    .first_fail_valid(fvldw));

  andor_stim_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_i(xs), .y_i(ys),
    .a_o(as_), .b_o(bs), .c_o(cs), .busy(busys), .done(dones),
    .pass(passs), .err_cnt(ecs), .fail_vec(fvs), .first_fail_idx(fis),
    .first_fail_valid(fvlds));

  function automatic logic [1:0] ideal(input logic [2:0] v);
    return {v[2] & v[1], v[1] | v[0]};
  endfunction

  // 3-cycle delayed gates for the main and SETTLE=4 instances
  logic [2:0] d1, d2, d3, e1, e2, e3;
  always @(posedge clk) begin
    d1 <= {a, b, c};
    d2 <= d1;
    d3 <= d2;
    e1 <= {as_, bs, cs};
    e2 <= e1;
    e3 <= e2;
  end

  logic [1:0] g;
  assign g = ideal({a, b, c});

  always_comb begin
    x = g[1];
    y = g[0];
    case (mode)
      1: x = 1'b0;
      2: y = 1'b1;
      3: begin x = ~g[1]; y = ~g[0]; end
      4: {x, y} = ideal(d3);
      default: ;
    endcase
  end

  assign {xw, yw} = ~ideal({aw, bw, cw});
  assign {xs, ys} = ideal(e3);

  // Delayed gate: at sample time it still shows the previous vector.
  function automatic res_t model(input int md, input int ew);
    res_t r;
    logic [1:0] o, e;
    logic [2:0] v, p;
    int cnt, mx;
    r = '0;
    cnt = 0;
    mx = (1 << ew) - 1;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      p = (i == 0) ? 3'd0 : v - 3'd1;
      e = ideal(v);
      case (md)
        0: o = e;
        1: o = {1'b0, e[0]};
        2: o = {e[1], 1'b1};
        3: o = ~e;
        default: o = ideal(p);
      endcase
      if (o !== e) begin
        r.fv[i] = 1'b1;
        cnt++;
        if (!r.fvld) begin
          r.fvld = 1'b1;
          r.fi = v;
        end
      end
    end
    r.ec = 4'((cnt > mx) ? mx : cnt);
    r.ps = (cnt == 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t r,
                         input logic [7:0] f, input logic [3:0] e,
                         input logic [2:0] i, input logic v,
                         input logic p);
    check({tag, "_fail_vec"}, f, r.fv);
    check({tag, "_err_cnt"}, e, r.ec);
    check({tag, "_first_idx"}, i, r.fi);
    check({tag, "_first_valid"}, v, r.fvld);
    check({tag, "_pass"}, p, r.ps);
  endtask

  task automatic sweep(input int md, input bit inject);
    int dm, dw, ds, bm;
    mode = md;
    q_main.push_back(model(md, 4));
    q_w2.push_back(model(3, 2));
    // SETTLE=4 covers the 3-cycle gate delay, so every vector passes.
    q_s4.push_back(model(0, 4));
    dm = 0; dw = 0; ds = 0; bm = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (busy) bm++;
      if (inject) start = (cyc >= 5 && cyc <= 20 && cyc % 3 == 0);
      if (cyc % 4 == 0 && cyc <= 32)
        check("abc_step", {29'd0, a, b, c}, (cyc / 4) - 1);
      if (done && dm == 0) begin
        dm = cyc;
        check("abc_done", {a, b, c}, 0);
        cmp_res("main", q_main.pop_front(), fv, ec, fi, fvld, pass);
      end
      if (donew && dw == 0) begin
        dw = cyc;
        cmp_res("w2", q_w2.pop_front(), fvw, {2'b00, ecw}, fiw,
                fvldw, passw);
      end
      if (dones && ds == 0) begin
        ds = cyc;
        cmp_res("s4", q_s4.pop_front(), fvs, ecs, fis, fvlds, passs);
      end
    end
    start = 1'b0;
    check("done_cycle", dm, 33);
    check("busy_cycles", bm, 32);
    check("w2_done_cycle", dw, 33);
    check("s4_done_cycle", ds, 49);
    q_main.delete();
    q_w2.delete();
    q_s4.delete();
  endtask

  initial begin
    int nd;
    int nb;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_abc", {a, b, c}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", ec, 0);
    check("rst_fail_vec", fv, 0);
    check("rst_first_idx", fi, 0);
    check("rst_first_valid", fvld, 0);
    @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 1'b0);
    sweep(1, 1'b0);
    sweep(2, 1'b0);
    sweep(3, 1'b0);
    sweep(4, 1'b0);
    sweep(0, 1'b1);

    // Reset while vector 3 settles; Y stuck-at-1 already failed vector 0.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("mid_abc", {29'd0, a, b, c}, 3);
    check("mid_err_cnt", ec, 1);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_abc", {a, b, c}, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err_cnt", ec, 0);
    check("mrst_fail_vec", fv, 0);
    check("mrst_first_valid", fvld, 0);
    check("mrst_w2_busy", busyw, 0);
    check("mrst_s4_busy", busys, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_beats_start", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
      if (busy) nb++;
    end
    check("post_rst_no_done", nd, 0);
    check("post_rst_no_busy", nb, 0);

    sweep(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
